branch_unit: RTL and testbench

Resolves control transfers in the RV32I core's execute stage. It consumes the ALU's Z/N flags, produced by a SUB with is_signed set per branch type, to decide conditional branches, and it computes targets for JAL and JALR. Fetch uses a static not-taken policy, so every taken transfer issues a registered redirect through a valid/ready handshake to fetch. After fetch accepts the redirect, the unit squashes a fixed number of younger slots and keeps saturating branch statistics.

---
 rtl/branch_unit.sv | 176 +++++++++++++++++
 tb/tb_branch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_unit
// Description : Execute-stage control-transfer resolver for an RV32I core.
//               Decodes conditional branches from ALU Z/N flags, computes
//               JAL/JALR targets, issues a registered redirect to fetch over
//               a valid/ready handshake, squashes younger slots afterwards
//               and keeps saturating branch statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_unit #(
    parameter int KILL_CYCLES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [1:0]       br_kind,
    input  logic [2:0]       funct3,
    input  logic             Z,
    input  logic             N,
    input  logic [31:0]      pc,
    input  logic [31:0]      imm,
    input  logic [31:0]      alu_result,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [31:0]      redirect_pc,
    output logic             squash,
    output logic             link_valid,
    output logic [31:0]      link_addr,
    output logic             misalign,
    output logic             illegal,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    // Kill counter needs to hold KILL_CYCLES; keep at least one bit for KILL_CYCLES=0.
    localparam int c_KW = (KILL_CYCLES > 0) ? $clog2(KILL_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_SQUASH   = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_KW-1:0]   r_kill_cnt;
    logic [31:0]       r_redirect_pc;
    logic              r_link_valid;
    logic [31:0]       r_link_addr;
    logic              r_misalign;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_branch_cnt;
    logic [CNT_W-1:0]  r_taken_cnt;

    logic              w_accept;
    logic              w_is_br;
    logic              w_is_jump;
    logic              w_is_jalr;
    logic              w_bad_f3;
    logic              w_illegal;
    logic              w_cond;
    logic              w_br_taken;
    logic              w_taken;
    logic [31:0]       w_target;
    logic              w_target_mis;

    assign w_accept     = br_valid && (r_state == ST_IDLE);
    assign w_is_br      = (br_kind == 2'b00);
    assign w_is_jalr    = (br_kind == 2'b10);
    assign w_is_jump    = (br_kind == 2'b01) || w_is_jalr;
    assign w_bad_f3     = (funct3[2:1] == 2'b01);
    assign w_illegal    = (w_is_br && w_bad_f3) || (br_kind == 2'b11);
    assign w_br_taken   = w_is_br && !w_bad_f3 && w_cond;
    assign w_taken      = w_br_taken || w_is_jump;
    // JALR clears bit 0 of rs1+imm; branches and JAL add the offset to pc.
    assign w_target     = w_is_jalr ? (alu_result & ~32'h1) : (pc + imm);
    assign w_target_mis = w_target[1];

    // Branch condition from the ALU flags; signedness was already chosen upstream.
    always_comb begin
        w_cond = 1'b0;
        case (funct3)
            3'b000:  w_cond = Z;
            3'b001:  w_cond = !Z;
            3'b100:  w_cond = N;
            3'b101:  w_cond = !N;
            3'b110:  w_cond = N;
            3'b111:  w_cond = !N;
            default: w_cond = 1'b0;
        endcase
    end

    // Redirect / squash sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_kill_cnt    <= '0;
            r_redirect_pc <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_taken && !w_target_mis) begin
                        r_state       <= ST_REDIRECT;
                        r_redirect_pc <= w_target;
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        if (KILL_CYCLES > 0) begin
                            r_state    <= ST_SQUASH;
                            r_kill_cnt <= c_KW'(KILL_CYCLES);
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_SQUASH: begin
                    if (r_kill_cnt <= c_KW'(1)) begin
                        r_state    <= ST_IDLE;
                        r_kill_cnt <= '0;
                    end else begin
                        r_kill_cnt <= r_kill_cnt - c_KW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // One-cycle status pulses and the link address for JAL/JALR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_link_valid <= 1'b0;
            r_link_addr  <= 32'h0;
            r_misalign   <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_link_valid <= w_accept && w_is_jump;
            r_misalign   <= w_accept && w_taken && w_target_mis;
            r_illegal    <= w_accept && w_illegal;
            if (w_accept && w_is_jump) begin
                r_link_addr <= pc + 32'd4;
            end
        end
    end

    // Saturating statistics for conditional branches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else begin
            if (w_accept && w_is_br && !w_bad_f3 && !(&r_branch_cnt)) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_accept && w_br_taken && !(&r_taken_cnt)) begin
                r_taken_cnt <= r_taken_cnt + CNT_W'(1);
            end
        end
    end

    assign br_ready       = (r_state == ST_IDLE);
    assign redirect_valid = (r_state == ST_REDIRECT);
    assign squash         = (r_state == ST_SQUASH);
    assign redirect_pc    = r_redirect_pc;
    assign link_valid     = r_link_valid;
    assign link_addr      = r_link_addr;
    assign misalign       = r_misalign;
    assign illegal        = r_illegal;
    assign branch_cnt     = r_branch_cnt;
    assign taken_cnt      = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_unit
// Description : Directed self-checking bench for branch_unit. Main instance
//               uses KILL_CYCLES=2 / CNT_W=2; a second instance with
//               KILL_CYCLES=0 shares the inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_valid;
    logic [1:0]  br_kind;
    logic [2:0]  funct3;
    logic        Z;
    logic        N;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic        redirect_ready;

    logic        br_ready, redirect_valid, squash, link_valid, misalign, illegal;
    logic [31:0] redirect_pc, link_addr;
    logic [1:0]  branch_cnt, taken_cnt;

    logic        k0_br_ready, k0_redirect_valid, k0_squash, k0_link_valid, k0_misalign, k0_illegal;
    logic [31:0] k0_redirect_pc, k0_link_addr;
    logic [31:0] k0_branch_cnt, k0_taken_cnt;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    branch_unit #(.KILL_CYCLES(2), .CNT_W(2)) u_dut (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready),
        .br_kind(br_kind), .funct3(funct3), .Z(Z), .N(N), .pc(pc), .imm(imm),
        .alu_result(alu_result), .redirect_valid(redirect_valid),
        .redirect_ready(redirect_ready), .redirect_pc(redirect_pc),
        .squash(squash), .link_valid(link_valid), .link_addr(link_addr),
        .misalign(misalign), .illegal(illegal),
        .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    branch_unit #(.KILL_CYCLES(0), .CNT_W(32)) u_dut_k0 (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(k0_br_ready),
        .br_kind(br_kind), .funct3(funct3), .Z(Z), .N(N), .pc(pc), .imm(imm),
        .alu_result(alu_result), .redirect_valid(k0_redirect_valid),
        .redirect_ready(redirect_ready), .redirect_pc(k0_redirect_pc),
        .squash(k0_squash), .link_valid(k0_link_valid), .link_addr(k0_link_addr),
        .misalign(k0_misalign), .illegal(k0_illegal),
        .branch_cnt(k0_branch_cnt), .taken_cnt(k0_taken_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        br_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drive(input logic [1:0] k, input logic [2:0] f3, input logic z, input logic n,
                         input logic [31:0] p, input logic [31:0] im, input logic [31:0] alu);
        br_valid   = 1'b1;
        br_kind    = k;
        funct3     = f3;
        Z          = z;
        N          = n;
        pc         = p;
        imm        = im;
        alu_result = alu;
    endtask

    initial begin
        redirect_ready = 1'b0;
        drive(2'b00, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        br_valid = 1'b0;
        do_reset();

        // Reset state
        chk("rst_br_ready",    32'(br_ready), 32'd1);
        chk("rst_redir_valid", 32'(redirect_valid), 32'd0);
        chk("rst_redir_pc",    redirect_pc, 32'h0);
        chk("rst_squash",      32'(squash), 32'd0);
        chk("rst_link_addr",   link_addr, 32'h0);
        chk("rst_pulses",      {29'd0, link_valid, misalign, illegal}, 32'd0);
        chk("rst_cnts",        {28'd0, branch_cnt, taken_cnt}, 32'd0);

        // BEQ taken, immediate handshake, 2 squash cycles
        drive(2'b00, 3'b000, 1'b1, 1'b0, 32'h100, 32'h20, 32'h0);
        redirect_ready = 1'b1;
        tick();
        br_valid = 1'b0;
        chk("beq_redir_valid", 32'(redirect_valid), 32'd1);
        chk("beq_redir_pc",    redirect_pc, 32'h120);
        chk("beq_br_ready",    32'(br_ready), 32'd0);
        chk("beq_branch_cnt",  32'(branch_cnt), 32'd1);
        chk("beq_taken_cnt",   32'(taken_cnt), 32'd1);
        chk("k0_beq_redir",    32'(k0_redirect_valid), 32'd1);
        tick();
        chk("beq_squash1",     32'(squash), 32'd1);
        chk("beq_redir_done",  32'(redirect_valid), 32'd0);
        chk("k0_idle_after",   32'(k0_br_ready), 32'd1);
        chk("k0_no_squash",    32'(k0_squash), 32'd0);
        tick();
        chk("beq_squash2",     32'(squash), 32'd1);
        chk("beq_ready_low",   32'(br_ready), 32'd0);
        tick();
        chk("beq_squash_end",  32'(squash), 32'd0);
        chk("beq_ready_back",  32'(br_ready), 32'd1);
        redirect_ready = 1'b0;

        // BNE (Z=1) then BGEU (N=1) back to back, both not taken
        do_reset();
        drive(2'b00, 3'b001, 1'b1, 1'b0, 32'h400, 32'h40, 32'h0);
        tick();
        chk("bne_br_ready",    32'(br_ready), 32'd1);
        chk("bne_no_redir",    32'(redirect_valid), 32'd0);
        chk("bne_branch_cnt",  32'(branch_cnt), 32'd1);
        drive(2'b00, 3'b111, 1'b0, 1'b1, 32'h404, 32'h40, 32'h0);
        tick();
        br_valid = 1'b0;
        chk("bgeu_no_redir",   32'(redirect_valid), 32'd0);
        chk("bgeu_no_squash",  32'(squash), 32'd0);
        chk("bgeu_branch_cnt", 32'(branch_cnt), 32'd2);
        chk("bgeu_taken_cnt",  32'(taken_cnt), 32'd0);

        // BLT taken with negative offset, fetch stalls 3 cycles
        do_reset();
        drive(2'b00, 3'b100, 1'b0, 1'b1, 32'h200, 32'hFFFF_FFF8, 32'h0);
        redirect_ready = 1'b0;
        tick();
        // Offer another taken BEQ that must be ignored while busy
        drive(2'b00, 3'b000, 1'b1, 1'b0, 32'h0, 32'h40, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("blt_hold_valid", 32'(redirect_valid), 32'd1);
            chk("blt_hold_pc",    redirect_pc, 32'h1F8);
            chk("blt_hold_ready", 32'(br_ready), 32'd0);
            tick();
        end
        chk("blt_valid_4th",   32'(redirect_valid), 32'd1);
        chk("blt_pc_4th",      redirect_pc, 32'h1F8);
        redirect_ready = 1'b1;
        br_valid = 1'b0;
        tick();
        chk("blt_squash1",     32'(squash), 32'd1);
        chk("blt_redir_off",   32'(redirect_valid), 32'd0);
        chk("blt_branch_cnt",  32'(branch_cnt), 32'd1);
        chk("blt_taken_cnt",   32'(taken_cnt), 32'd1);
        tick();
        chk("blt_squash2",     32'(squash), 32'd1);
        tick();
        chk("blt_ready_back",  32'(br_ready), 32'd1);
        chk("blt_squash_off",  32'(squash), 32'd0);

        // JALR: bit 0 cleared, link pulse, counters unchanged
        drive(2'b10, 3'b000, 1'b0, 1'b0, 32'h300, 32'h5, 32'h2005);
        tick();
        br_valid = 1'b0;
        chk("jalr_redir_valid", 32'(redirect_valid), 32'd1);
        chk("jalr_redir_pc",    redirect_pc, 32'h2004);
        chk("jalr_link_valid",  32'(link_valid), 32'd1);
        chk("jalr_link_addr",   link_addr, 32'h304);
        chk("jalr_no_misalign", 32'(misalign), 32'd0);
        chk("jalr_cnts",        {28'd0, branch_cnt, taken_cnt}, {28'd0, 2'd1, 2'd1});
        tick();
        chk("jalr_link_pulse",  32'(link_valid), 32'd0);
        tick();
        tick();
        chk("jalr_ready_back",  32'(br_ready), 32'd1);

        // JAL to a misaligned target: misalign + link, no redirect
        drive(2'b01, 3'b000, 1'b0, 1'b0, 32'h100, 32'h6, 32'h0);
        tick();
        chk("jal_misalign",     32'(misalign), 32'd1);
        chk("jal_link_valid",   32'(link_valid), 32'd1);
        chk("jal_link_addr",    link_addr, 32'h104);
        chk("jal_no_redir",     32'(redirect_valid), 32'd0);
        chk("jal_ready",        32'(br_ready), 32'd1);
        // funct3=010 illegal, not taken, not counted
        drive(2'b00, 3'b010, 1'b1, 1'b1, 32'h100, 32'h20, 32'h0);
        tick();
        br_valid = 1'b0;
        chk("ill_pulse",        32'(illegal), 32'd1);
        chk("ill_others",       {29'd0, link_valid, misalign, redirect_valid}, 32'd0);
        chk("ill_branch_cnt",   32'(branch_cnt), 32'd1);
        tick();
        chk("ill_pulse_end",    32'(illegal), 32'd0);
        // Reserved kind 11 is illegal as well
        drive(2'b11, 3'b000, 1'b1, 1'b0, 32'h100, 32'h20, 32'h0);
        tick();
        br_valid = 1'b0;
        chk("rsv_illegal",      32'(illegal), 32'd1);
        chk("rsv_no_redir",     32'(redirect_valid), 32'd0);

        // Reset during REDIRECT abandons it
        drive(2'b00, 3'b000, 1'b1, 1'b0, 32'h500, 32'h10, 32'h0);
        redirect_ready = 1'b0;
        tick();
        br_valid = 1'b0;
        chk("pre_rst_redir",    32'(redirect_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_redir",    32'(redirect_valid), 32'd0);
        chk("rst_mid_ready",    32'(br_ready), 32'd1);
        chk("rst_mid_cnts",     {28'd0, branch_cnt, taken_cnt}, 32'd0);
        chk("rst_mid_pc",       redirect_pc, 32'h0);

        // Five taken BEQs: 2-bit counters saturate at 3
        redirect_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(2'b00, 3'b000, 1'b1, 1'b0, 32'h600, 32'h8, 32'h0);
            tick();
            br_valid = 1'b0;
            chk("sat_taken_cnt",  32'(taken_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
            chk("sat_branch_cnt", 32'(branch_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
            tick();
            tick();
            tick();
        end
        chk("k0_taken_32b",     k0_taken_cnt, 32'd5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
